// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller.
// Contents: the controller state encoding, CSR index map, interrupt cause
// codes and mstatus bit positions.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAVE_EPC,
    SAVE_CAUSE,
    SAVE_TVAL,
    UPD_STATUS,
    VECTOR,
    RET_STATUS,
    RET_PC
  } trap_state_t;

  localparam logic [3:0] CSR_MSTATUS = 4'd0;
  localparam logic [3:0] CSR_MIE     = 4'd2;
  localparam logic [3:0] CSR_MTVEC   = 4'd3;
  localparam logic [3:0] CSR_MEPC    = 4'd4;
  localparam logic [3:0] CSR_MCAUSE  = 4'd5;
  localparam logic [3:0] CSR_MTVAL   = 4'd6;
  localparam logic [3:0] CSR_MIP     = 4'd7;

  localparam logic [3:0] CAUSE_EXT = 4'd11;
  localparam logic [3:0] CAUSE_SW  = 4'd3;
  localparam logic [3:0] CAUSE_TMR = 4'd7;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_prio.sv
// Combinational trap priority encoder.
// Ports:
//   exc_valid, exc_cause        synchronous exception and its code
//   irq[2:0]                    raw lines {ext, sw, tmr}
//   mien, meien, msien, mtien   global and per-source interrupt enables
//   pending                     a trap should be taken
//   is_irq                      winner is an interrupt
//   code                        exception or interrupt cause code
// Priority: exception > external > software > timer.
module trap_prio
  import trap_pkg::*;
(
  input  logic       exc_valid,
  input  logic [3:0] exc_cause,
  input  logic [2:0] irq,
  input  logic       mien,
  input  logic       meien,
  input  logic       msien,
  input  logic       mtien,
  output logic       pending,
  output logic       is_irq,
  output logic [3:0] code
);

  always_comb begin
    pending = 1'b0;
    is_irq  = 1'b0;
    code    = '0;
    if (exc_valid) begin
      pending = 1'b1;
      code    = exc_cause;
    end else if (mien) begin
      if (irq[2] && meien) begin
        pending = 1'b1;
        is_irq  = 1'b1;
        code    = CAUSE_EXT;
      end else if (irq[1] && msien) begin
        pending = 1'b1;
        is_irq  = 1'b1;
        code    = CAUSE_SW;
      end else if (irq[0] && mtien) begin
        pending = 1'b1;
        is_irq  = 1'b1;
        code    = CAUSE_TMR;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / MRET sequencer.
// Accepts an exception or enabled interrupt in IDLE, then walks the CSR
// file one write per cycle (mepc, mcause, mtval, mstatus) before
// redirecting fetch to mtvec. MRET restores mstatus and redirects to mepc.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   irq, MIEN/MEIEN/MSIEN/MTIEN  interrupt lines and enables
//   exc_valid/exc_cause/exc_tval synchronous exception
//   mret, pc                     current instruction info
//   csr_rd_data                  combinational read of CSR[csr_add]
//   csr_add/csr_wr_data/csr_reg_write  CSR access port
//   handling_mode, busy          high whenever not IDLE
//   pc_load, pc_target           fetch redirect pulse
// Build option: define TRAP_CTRL_VECTORED_EN to honour mtvec[0] vectored
// mode for interrupts (base + 4*code); otherwise always base.
module trap_ctrl
  import trap_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  irq,
  input  logic        MIEN,
  input  logic        MEIEN,
  input  logic        MSIEN,
  input  logic        MTIEN,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_tval,
  input  logic        mret,
  input  logic [31:0] pc,
  input  logic [31:0] csr_rd_data,
  output logic [3:0]  csr_add,
  output logic [31:0] csr_wr_data,
  output logic        csr_reg_write,
  output logic        handling_mode,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        busy
);

  trap_state_t state, next_state;

  logic        pending, is_irq;
  logic [3:0]  code;
  logic        lat_is_irq;
  logic [3:0]  lat_code;
  logic [31:0] lat_pc, lat_tval;

  trap_prio u_prio (
    .exc_valid (exc_valid),
    .exc_cause (exc_cause),
    .irq       (irq),
    .mien      (MIEN),
    .meien     (MEIEN),
    .msien     (MSIEN),
    .mtien     (MTIEN),
    .pending   (pending),
    .is_irq    (is_irq),
    .code      (code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_is_irq <= 1'b0;
      lat_code   <= '0;
      lat_pc     <= '0;
      lat_tval   <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && pending) begin
        lat_is_irq <= is_irq;
        lat_code   <= code;
        lat_pc     <= pc;
        // Interrupts record no faulting value, so mtval is cleared.
        lat_tval   <= is_irq ? '0 : exc_tval;
      end
    end
  end

  always_comb begin
    next_state    = state;
    csr_add       = '0;
    csr_wr_data   = '0;
    csr_reg_write = 1'b0;
    pc_load       = 1'b0;
    pc_target     = '0;
    case (state)
      IDLE: begin
        // A pending trap outranks MRET; mepc then captures the MRET's pc.
        if (pending)   next_state = SAVE_EPC;
        else if (mret) next_state = RET_STATUS;
      end
      SAVE_EPC: begin
        csr_add       = CSR_MEPC;
        csr_wr_data   = lat_pc;
        csr_reg_write = 1'b1;
        next_state    = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        csr_add       = CSR_MCAUSE;
        csr_wr_data   = {lat_is_irq, 27'b0, lat_code};
        csr_reg_write = 1'b1;
        next_state    = SAVE_TVAL;
      end
      SAVE_TVAL: begin
        csr_add       = CSR_MTVAL;
        csr_wr_data   = lat_tval;
        csr_reg_write = 1'b1;
        next_state    = UPD_STATUS;
      end
      UPD_STATUS: begin
        csr_add                                    = CSR_MSTATUS;
        csr_wr_data                                = csr_rd_data;
        csr_wr_data[MSTATUS_MPIE]                  = csr_rd_data[MSTATUS_MIE];
        csr_wr_data[MSTATUS_MIE]                   = 1'b0;
        csr_wr_data[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        csr_reg_write                              = 1'b1;
        next_state                                 = VECTOR;
      end
      VECTOR: begin
        csr_add   = CSR_MTVEC;
        pc_load   = 1'b1;
        pc_target = {csr_rd_data[31:2], 2'b00};
`ifdef TRAP_CTRL_VECTORED_EN
        if (csr_rd_data[0] && lat_is_irq)
          pc_target = {csr_rd_data[31:2], 2'b00} + {26'b0, lat_code, 2'b00};
`endif
        next_state = IDLE;
      end
      RET_STATUS: begin
        csr_add                    = CSR_MSTATUS;
        csr_wr_data                = csr_rd_data;
        csr_wr_data[MSTATUS_MIE]   = csr_rd_data[MSTATUS_MPIE];
        csr_wr_data[MSTATUS_MPIE]  = 1'b1;
        csr_reg_write              = 1'b1;
        next_state                 = RET_PC;
      end
      RET_PC: begin
        csr_add    = CSR_MEPC;
        pc_load    = 1'b1;
        pc_target  = csr_rd_data;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy          = (state != IDLE);
  assign handling_mode = (state != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: a behavioural CSR file answers reads
// and commits writes at each clock edge; table vectors drive one trap or
// MRET each and check final CSR contents, redirect target and latency.
module tb_trap_ctrl;

`ifdef TRAP_CTRL_VECTORED_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif

  localparam logic [31:0] S = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  irq;
  logic        MIEN, MEIEN, MSIEN, MTIEN;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_tval;
  logic        mret;
  logic [31:0] pc;
  logic [31:0] csr_rd_data;
  logic [3:0]  csr_add;
  logic [31:0] csr_wr_data;
  logic        csr_reg_write;
  logic        handling_mode;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        busy;

  trap_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .irq           (irq),
    .MIEN          (MIEN),
    .MEIEN         (MEIEN),
    .MSIEN         (MSIEN),
    .MTIEN         (MTIEN),
    .exc_valid     (exc_valid),
    .exc_cause     (exc_cause),
    .exc_tval      (exc_tval),
    .mret          (mret),
    .pc            (pc),
    .csr_rd_data   (csr_rd_data),
    .csr_add       (csr_add),
    .csr_wr_data   (csr_wr_data),
    .csr_reg_write (csr_reg_write),
    .handling_mode (handling_mode),
    .pc_load       (pc_load),
    .pc_target     (pc_target),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  logic [31:0] csr [16];
  assign csr_rd_data = csr[csr_add];

  int checks = 0;
  int errors = 0;
  int cyc, wr_count, load_count, load_cyc, busy_cycles;
  logic [31:0] load_tgt;

  typedef struct {
    logic [2:0]  irq;
    logic        mien, meien, msien, mtien, exc;
    logic [3:0]  cause;
    logic [31:0] tval;
    logic        mret;
    logic [31:0] pc, mtvec, mstatus0, mepc0;
    int          exp_loads, exp_lat;
    logic [31:0] exp_tgt, exp_mepc, exp_mcause, exp_mtval, exp_mstatus;
    int          exp_writes, exp_busy;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: observe settled outputs at negedge, commit any CSR write just
  // after the following rising edge.
  task automatic tick();
    logic       w;
    logic [3:0] a;
    logic [31:0] d;
    @(negedge clk);
    w = csr_reg_write;
    a = csr_add;
    d = csr_wr_data;
    if (pc_load) begin
      if (load_count == 0) begin
        load_cyc = cyc;
        load_tgt = pc_target;
      end
      load_count++;
    end
    if (w) wr_count++;
    else chk("wr_data_idle", csr_wr_data, 32'h0);
    if (busy) busy_cycles++;
    @(posedge clk);
    #1;
    if (w) csr[a] = d;
    cyc++;
  endtask

  task automatic clear_inputs();
    irq = '0; MIEN = 0; MEIEN = 0; MSIEN = 0; MTIEN = 0;
    exc_valid = 0; exc_cause = '0; exc_tval = '0; mret = 0; pc = '0;
  endtask

  task automatic init_csr(input logic [31:0] mstatus0, input logic [31:0] mtvec,
                          input logic [31:0] mepc0);
    for (int unsigned i = 0; i < 16; i++) csr[i] = '0;
    csr[0] = mstatus0;
    csr[3] = mtvec;
    csr[4] = mepc0;
    csr[5] = S;
    csr[6] = S;
    cyc = 0; wr_count = 0; load_count = 0; load_cyc = -1; busy_cycles = 0;
    load_tgt = '0;
  endtask

  task automatic run(input vec_t v, input int idx);
    init_csr(v.mstatus0, v.mtvec, v.mepc0);
    irq = v.irq; MIEN = v.mien; MEIEN = v.meien; MSIEN = v.msien; MTIEN = v.mtien;
    exc_valid = v.exc; exc_cause = v.cause; exc_tval = v.tval; mret = v.mret; pc = v.pc;
    tick();
    // Request lines stay up while busy; the rest changes and must not leak in.
    pc = 32'hDEAD_0000; exc_tval = 32'h0000_0BAD; exc_cause = 4'hF;
    tick();
    tick();
    clear_inputs();
    repeat (7) tick();
    chk($sformatf("v%0d_loads", idx), load_count, v.exp_loads);
    if (v.exp_loads != 0) begin
      chk($sformatf("v%0d_latency", idx), load_cyc, v.exp_lat);
      chk($sformatf("v%0d_target", idx), load_tgt, v.exp_tgt);
    end
    chk($sformatf("v%0d_mepc", idx), csr[4], v.exp_mepc);
    chk($sformatf("v%0d_mcause", idx), csr[5], v.exp_mcause);
    chk($sformatf("v%0d_mtval", idx), csr[6], v.exp_mtval);
    chk($sformatf("v%0d_mstatus", idx), csr[0], v.exp_mstatus);
    chk($sformatf("v%0d_mtvec", idx), csr[3], v.mtvec);
    chk($sformatf("v%0d_writes", idx), wr_count, v.exp_writes);
    chk($sformatf("v%0d_busy_cycles", idx), busy_cycles, v.exp_busy);
  endtask

  initial begin
    //            irq    mi me ms mt ex cause tval          mret pc            mtvec         mstatus0      mepc0
    //            loads lat target                        mepc          mcause         mtval         mstatus     wr busy
    vt[0]  = '{3'b000, 0,0,0,0, 1, 4'd2, 32'hDEAD,     0, 32'h40,       32'h100,      32'h8,        32'h0,
               1, 5, 32'h100,                            32'h40,       32'h2,         32'hDEAD,     32'h1880, 4, 5};
    vt[1]  = '{3'b101, 1,1,0,1, 0, 4'd0, 32'h77,       0, 32'h1000,     32'h201,      32'h8,        32'h0,
               1, 5, VEC_EN ? 32'h22C : 32'h200,         32'h1000,     32'h8000000B,  32'h0,        32'h1880, 4, 5};
    vt[2]  = '{3'b111, 0,1,1,1, 0, 4'd0, 32'h0,        0, 32'h1000,     32'h100,      32'h8,        32'h55,
               0, 0, 32'h0,                              32'h55,       S,             S,            32'h8,    0, 0};
    vt[3]  = '{3'b000, 0,0,0,0, 0, 4'd0, 32'h0,        1, 32'h10,       32'h100,      32'h80,       32'h80,
               1, 2, 32'h80,                             32'h80,       S,             S,            32'h88,   1, 2};
    vt[4]  = '{3'b010, 1,0,1,0, 0, 4'd0, 32'h0,        0, 32'h2000,     32'h300,      32'h0,        32'h0,
               1, 5, 32'h300,                            32'h2000,     32'h80000003,  32'h0,        32'h1800, 4, 5};
    vt[5]  = '{3'b001, 1,0,0,1, 0, 4'd0, 32'h0,        0, 32'h3000,     32'h401,      32'h1808,     32'h0,
               1, 5, VEC_EN ? 32'h41C : 32'h400,         32'h3000,     32'h80000007,  32'h0,        32'h1880, 4, 5};
    vt[6]  = '{3'b000, 0,0,0,0, 1, 4'd5, 32'h1234,     1, 32'h500,      32'h601,      32'h88,       32'h999,
               1, 5, 32'h600,                            32'h500,      32'h5,         32'h1234,     32'h1880, 4, 5};
    vt[7]  = '{3'b100, 1,1,0,0, 0, 4'd0, 32'h0,        1, 32'h700,      32'h100,      32'h8,        32'h999,
               1, 5, 32'h100,                            32'h700,      32'h8000000B,  32'h0,        32'h1880, 4, 5};
    vt[8]  = '{3'b111, 1,1,1,1, 1, 4'hB, 32'hCAFE,     0, 32'h900,      32'h201,      32'h0,        32'h0,
               1, 5, 32'h200,                            32'h900,      32'hB,         32'hCAFE,     32'h1800, 4, 5};
    vt[9]  = '{3'b110, 1,0,1,0, 0, 4'd0, 32'h0,        0, 32'hA00,      32'h101,      32'h0,        32'h0,
               1, 5, VEC_EN ? 32'h10C : 32'h100,         32'hA00,      32'h80000003,  32'h0,        32'h1800, 4, 5};
    vt[10] = '{3'b000, 0,0,0,0, 0, 4'd0, 32'h0,        1, 32'h10,       32'h100,      32'h8,        32'h1234,
               1, 2, 32'h1234,                           32'h1234,     S,             S,            32'h80,   1, 2};

    clear_inputs();
    init_csr(32'h8, 32'h100, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_handling", handling_mode, 1'b0);
    chk("rst_pc_load", pc_load, 1'b0);
    chk("rst_pc_target", pc_target, 32'h0);
    chk("rst_wr", csr_reg_write, 1'b0);
    chk("rst_wr_data", csr_wr_data, 32'h0);
    chk("rst_add", {28'h0, csr_add}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run(vt[i], i);

    // Reset while the entry sequence sits in SAVE_TVAL.
    init_csr(32'h8, 32'h100, 32'h0);
    exc_valid = 1; exc_cause = 4'd2; exc_tval = 32'hDEAD; pc = 32'h40;
    tick();                       // IDLE, accepted
    clear_inputs();
    tick();                       // SAVE_EPC
    tick();                       // SAVE_CAUSE
    chk("midrst_in_tval", busy, 1'b1);
    rst = 1'b1;
    tick();                       // SAVE_TVAL, reset sampled at its end
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_handling", handling_mode, 1'b0);
    chk("midrst_wr", csr_reg_write, 1'b0);
    @(posedge clk);
    #1;
    repeat (6) tick();
    chk("midrst_loads", load_count, 0);
    chk("midrst_writes", wr_count, 3);
    chk("midrst_mstatus", csr[0], 32'h8);
    chk("midrst_mepc", csr[4], 32'h40);
    chk("midrst_mcause", csr[5], 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
